// File: rtl/proc_mem_responder_if.sv
// Core-facing memory bus: instruction fetch port plus data load/store port.
// The core drives addresses and strobes. The responder returns instruction and load data.
interface proc_mem_responder_if;
    logic [7:0]  insaddr;
    logic [15:0] insdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  data_addr;
    logic [7:0]  data_write;
    logic [7:0]  data_read;

    modport master (
        output insaddr, mem_read, mem_write, data_addr, data_write,
        input  insdata, data_read
    );

    modport slave (
        input  insaddr, mem_read, mem_write, data_addr, data_write,
        output insdata, data_read
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the 8-bit core: instruction RAM, data RAM with one I/O register,
// and a byte-serial program loader that holds the core in reset while it fills instruction RAM.
module proc_mem_responder #(
    parameter logic [7:0]  IO_ADDR  = 8'hFF,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    proc_mem_responder_if.slave        bus,
    input  logic [7:0]                 io_in,
    output logic [7:0]                 io_out,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [7:0]                 load_byte,
    input  logic                       load_end,
    output logic                       core_rst,
    output logic                       load_busy,
    output logic [8:0]                 load_count,
    output logic                       load_err
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t      state, state_nxt;
    logic [7:0]  ptr, ptr_nxt;
    logic [7:0]  hold, hold_nxt;
    logic [8:0]  count_nxt;
    logic        err_nxt;
    logic        imem_we;
    logic        dmem_we;
    logic        io_we;
    logic        unused_mem_read;

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 8'd0;
            hold       <= 8'd0;
            load_count <= 9'd0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold       <= hold_nxt;
            load_count <= count_nxt;
            load_err   <= err_nxt;
        end
    end

    // A byte arriving with load_end is consumed before the load closes; an unpaired byte flags an error.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold;
        count_nxt = load_count;
        err_nxt   = load_err;
        imem_we   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = HI;
                    ptr_nxt   = 8'd0;
                    count_nxt = 9'd0;
                    err_nxt   = 1'b0;
                end
            end
            HI, LO: begin
                if (load_start) begin
                    state_nxt = HI;
                    ptr_nxt   = 8'd0;
                    count_nxt = 9'd0;
                    err_nxt   = 1'b0;
                end else begin
                    if (load_valid) begin
                        if (state == HI) begin
                            hold_nxt  = load_byte;
                            state_nxt = LO;
                        end else begin
                            imem_we   = 1'b1;
                            ptr_nxt   = ptr + 8'd1;
                            state_nxt = HI;
                            if (load_count == 9'd256)
                                err_nxt = 1'b1;
                            else
                                count_nxt = load_count + 9'd1;
                        end
                    end
                    if (load_end) begin
                        state_nxt = IDLE;
                        if ((state == LO) != load_valid)
                            err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (imem_we)
            imem[ptr] <= {hold, load_byte};
    end

    assign load_busy = (state != IDLE);
    assign core_rst  = rst | load_busy;

    assign io_we   = bus.mem_write & ~load_busy & (bus.data_addr == IO_ADDR);
    assign dmem_we = bus.mem_write & ~load_busy & (bus.data_addr != IO_ADDR);

    always_ff @(posedge clk) begin
        if (dmem_we)
            dmem[bus.data_addr] <= bus.data_write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            io_out <= 8'd0;
        else if (io_we)
            io_out <= bus.data_write;
    end

    // Reads are combinational so a load writes back in the same cycle; mem_read only qualifies intent.
    assign bus.data_read    = (bus.data_addr == IO_ADDR) ? io_in : dmem[bus.data_addr];
    assign bus.insdata      = load_busy ? NOP_WORD : imem[bus.insaddr];
    assign unused_mem_read  = bus.mem_read;

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Memory-side responder for the 8-bit processor core's two memory interfaces.
- Instruction port: receives insaddr, returns a 16-bit word. Data port: receives mem_read/mem_write/data_addr/data_write, returns data_read.
- Contains a byte-serial program loader FSM that fills instruction memory while holding the core in reset.
- Maps one data address to an I/O register instead of RAM.

Parameters:
- IO_ADDR, 8'hFF: data address decoded as the I/O port instead of RAM.
- NOP_WORD, 16'h0000: instruction returned while a load is in progress.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- insaddr  in  8  instruction fetch address from the core.
- insdata  out  16  instruction word to the core.
- mem_read  in  1  core data read strobe.
- mem_write  in  1  core data write strobe.
- data_addr  in  8  core data address.
- data_write  in  8  core store data.
- data_read  out  8  load data to the core.
- io_in  in  8  external input, read at IO_ADDR.
- io_out  out  8  registered output, written at IO_ADDR.
- load_start  in  1  one-cycle pulse: begin a program load.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte stream, high byte of each word first.
- load_end  in  1  one-cycle pulse: finish the load.
- core_rst  out  1  reset to the core.
- load_busy  out  1  loader is active.
- load_count  out  9  words written by the current or last load (0..256).
- load_err  out  1  sticky error flag.

Behaviour:
- Storage: imem is 256x16, dmem is 256x8. Neither array is cleared by rst.
- Reset values: io_out=0, load_count=0, load_err=0, load_busy=0, FSM=IDLE, write pointer=0. core_rst = rst OR load_busy, combinational, so it is 1 during rst.
- Instruction read: combinational, zero latency. insdata = imem[insaddr] when load_busy=0, else NOP_WORD.
- Data read: combinational, zero latency, because the core's LM writes back in the same cycle.
  - data_read = io_in if data_addr==IO_ADDR, else dmem[data_addr].
  - data_read is driven regardless of mem_read; mem_read is informational only.
- Data write: on the rising clk edge with mem_write=1.
  - data_addr==IO_ADDR: io_out <= data_write; dmem is not written.
  - Otherwise dmem[data_addr] <= data_write.
  - Ignored while load_busy=1.
- mem_read and mem_write both high: the write occurs at the edge; data_read in that cycle shows the pre-write value (read-before-write).
- Loader FSM states: IDLE, HI, LO.
  - IDLE, load_start=1: ptr<=0, load_count<=0, load_err<=0, load_busy<=1, go to HI.
  - HI, load_valid=1: hold<=load_byte, go to LO.
  - LO, load_valid=1: imem[ptr] <= {hold, load_byte}; ptr<=ptr+1 (8-bit wrap); load_count<=load_count+1 (saturates at 256); go to HI.
  - HI or LO, load_valid=0: stay in state.
  - HI or LO, load_end=1: load_busy<=0, go to IDLE. If in LO (odd byte count), the held byte is discarded and load_err<=1.
  - load_end and load_valid in the same cycle: the byte is processed first. A LO-state word is written and the load then ends cleanly with no error.
  - 257th word: ptr wraps to 0 and overwrites imem[0]; load_err<=1; load_count stays 256.
  - load_start while busy: restarts the load (ptr=0, count=0, error cleared, state HI).
  - load_end in IDLE: ignored. load_valid in IDLE: ignored.
- core_rst falls in the cycle after the load_end edge, so the core restarts at pc=0.
- rst asserted mid-load: the FSM aborts to IDLE immediately. imem keeps the words already written.
- No clock enable; all sequential logic is on the rising clk edge.

Test Plan:
- Reset then load: load_start, bytes 80,05,01,40 -> imem[0]=16'h8005, imem[1]=16'h0140, load_count=2, load_err=0, core_rst=1 during the load and 0 one cycle after load_end; insdata=16'h8005 at insaddr=0.
- Odd-byte load: load_start, bytes 12,34,56, load_end -> imem[0]=16'h1234, imem[1] unchanged, load_count=1, load_err=1.
- Data RAM: mem_write, addr 8'h10, data 8'hA5 -> next cycle data_read=8'hA5 at addr 8'h10. In a simultaneous read+write of 8'h5A to the same address, data_read=8'hA5 in that cycle and 8'h5A afterwards.
- I/O map: write 8'h3C to 8'hFF -> io_out=8'h3C, dmem[8'hFF] unchanged; io_in=8'h77, read 8'hFF -> data_read=8'h77.
- Overflow: load 257 words, word k = 16'h1000+k -> imem[0]=16'h1100, load_count=256, load_err=1.
- Mid-load rst and blocked writes: mem_write to 8'h20 while load_busy=1 -> dmem[8'h20] unchanged. Assert rst during HI -> load_busy=0, io_out=0, state IDLE, core_rst=1 while rst is high.
